// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, memory-stage and bus signals of the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/bus-slave view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_err;

    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    logic        bus_req;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [63:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_ready, if_err,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err,
        output bus_req, bus_we, bus_size, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack, bus_err
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_ready, if_err,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err,
        input  bus_req, bus_we, bus_size, bus_addr, bus_wdata,
        output bus_rdata, bus_ack, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle bus port between fetch and memory stage: data-over-fetch priority,
// bus timeout with access fault, flushed-fetch discard. Optional macro ARB_STARVE_GUARD_EN bounds MEM bursts.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TIMEOUT_W      = 7
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned MAX_MEM_BURST  = 4
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  port
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUSY_IF  = 3'd1,
        ST_BUSY_MEM = 3'd2,
        ST_DONE_IF  = 3'd3,
        ST_DONE_MEM = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_r, state_s;
    logic [TIMEOUT_W-1:0]  cnt_r, cnt_s;
    logic                  flush_r, flush_s;
    logic                  bus_req_r, bus_req_s;
    logic                  bus_we_r, bus_we_s;
    logic [1:0]            bus_size_r, bus_size_s;
    logic [63:0]           bus_addr_r, bus_addr_s;
    logic [63:0]           bus_wdata_r, bus_wdata_s;
    logic [31:0]           if_rdata_r, if_rdata_s;
    logic                  if_ready_r, if_ready_s;
    logic                  if_err_r, if_err_s;
    logic [63:0]           mem_rdata_r, mem_rdata_s;
    logic                  mem_ready_r, mem_ready_s;
    logic                  mem_err_r, mem_err_s;
    logic                  force_if_s;
    logic                  grant_mem_s;
    logic                  grant_if_s;
    logic                  timeout_s;
    logic                  flush_any_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned BURST_W = $clog2(MAX_MEM_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_MEM_BURST);

    logic [BURST_W-1:0] burst_r;

    // IF is forced to win once MEM has taken MAX_MEM_BURST grants in a row over a waiting fetch.
    assign force_if_s = port.if_req && (burst_r == BURST_MAX);

    // Consecutive MEM-grants-while-fetch-waits counter, evaluated only at IDLE arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_r <= {BURST_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (grant_if_s || !port.if_req) begin
                burst_r <= {BURST_W{1'b0}};
            end else if (grant_mem_s) begin
                burst_r <= burst_r + {{(BURST_W-1){1'b0}}, 1'b1};
            end else begin
                burst_r <= burst_r;
            end
        end else begin
            burst_r <= burst_r;
        end
    end
`else
    assign force_if_s = 1'b0;
`endif

    assign grant_mem_s = port.mem_req && !force_if_s;
    assign grant_if_s  = port.if_req && !grant_mem_s;
    assign timeout_s   = (cnt_r == TIMEOUT_LAST);
    assign flush_any_s = flush_r || port.if_flush;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        flush_s     = flush_r;
        bus_req_s   = bus_req_r;
        bus_we_s    = bus_we_r;
        bus_size_s  = bus_size_r;
        bus_addr_s  = bus_addr_r;
        bus_wdata_s = bus_wdata_r;
        if_rdata_s  = if_rdata_r;
        if_ready_s  = 1'b0;
        if_err_s    = 1'b0;
        mem_rdata_s = mem_rdata_r;
        mem_ready_s = 1'b0;
        mem_err_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_s   = {TIMEOUT_W{1'b0}};
                flush_s = 1'b0;
                if (grant_mem_s) begin
                    state_s     = ST_BUSY_MEM;
                    bus_req_s   = 1'b1;
                    bus_we_s    = port.mem_we;
                    bus_size_s  = port.mem_size;
                    bus_addr_s  = port.mem_addr;
                    bus_wdata_s = port.mem_wdata;
                end else if (grant_if_s) begin
                    state_s     = ST_BUSY_IF;
                    bus_req_s   = 1'b1;
                    bus_we_s    = 1'b0;
                    bus_size_s  = 2'd2;
                    bus_addr_s  = port.if_addr;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_BUSY_IF: begin
                cnt_s   = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                flush_s = flush_any_s;
                // A flush seen at any point of the fetch, including the ack edge, silences completion.
                if (port.bus_ack) begin
                    state_s    = ST_DONE_IF;
                    bus_req_s  = 1'b0;
                    flush_s    = 1'b0;
                    if_rdata_s = bus_addr_r[2] ? port.bus_rdata[63:32] : port.bus_rdata[31:0];
                    if_ready_s = !flush_any_s;
                    if_err_s   = port.bus_err && !flush_any_s;
                end else if (timeout_s) begin
                    state_s    = ST_DONE_IF;
                    bus_req_s  = 1'b0;
                    flush_s    = 1'b0;
                    if_rdata_s = 32'd0;
                    if_ready_s = !flush_any_s;
                    if_err_s   = !flush_any_s;
                end else begin
                    state_s = ST_BUSY_IF;
                end
            end

            ST_BUSY_MEM: begin
                cnt_s = cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                if (port.bus_ack) begin
                    state_s     = ST_DONE_MEM;
                    bus_req_s   = 1'b0;
                    mem_rdata_s = port.bus_rdata;
                    mem_ready_s = 1'b1;
                    mem_err_s   = port.bus_err;
                end else if (timeout_s) begin
                    state_s     = ST_DONE_MEM;
                    bus_req_s   = 1'b0;
                    mem_rdata_s = 64'd0;
                    mem_ready_s = 1'b1;
                    mem_err_s   = 1'b1;
                end else begin
                    state_s = ST_BUSY_MEM;
                end
            end

            ST_DONE_IF: begin
                state_s = ST_IDLE;
            end

            ST_DONE_MEM: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s   = ST_IDLE;
                bus_req_s = 1'b0;
                flush_s   = 1'b0;
                cnt_s     = {TIMEOUT_W{1'b0}};
            end
        endcase
    end

    // State and registered-output update; reset clears everything and drops BUS_REQ at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {TIMEOUT_W{1'b0}};
            flush_r     <= 1'b0;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_size_r  <= 2'd0;
            bus_addr_r  <= 64'd0;
            bus_wdata_r <= 64'd0;
            if_rdata_r  <= 32'd0;
            if_ready_r  <= 1'b0;
            if_err_r    <= 1'b0;
            mem_rdata_r <= 64'd0;
            mem_ready_r <= 1'b0;
            mem_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            flush_r     <= flush_s;
            bus_req_r   <= bus_req_s;
            bus_we_r    <= bus_we_s;
            bus_size_r  <= bus_size_s;
            bus_addr_r  <= bus_addr_s;
            bus_wdata_r <= bus_wdata_s;
            if_rdata_r  <= if_rdata_s;
            if_ready_r  <= if_ready_s;
            if_err_r    <= if_err_s;
            mem_rdata_r <= mem_rdata_s;
            mem_ready_r <= mem_ready_s;
            mem_err_r   <= mem_err_s;
        end
    end

    assign port.bus_req   = bus_req_r;
    assign port.bus_we    = bus_we_r;
    assign port.bus_size  = bus_size_r;
    assign port.bus_addr  = bus_addr_r;
    assign port.bus_wdata = bus_wdata_r;
    assign port.if_rdata  = if_rdata_r;
    assign port.if_ready  = if_ready_r;
    assign port.if_err    = if_err_r;
    assign port.mem_rdata = mem_rdata_r;
    assign port.mem_ready = mem_ready_r;
    assign port.mem_err   = mem_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: fetch, contention, timeout, flush, bus error, reset, starvation.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_port_arbiter_if u_if ();

    mem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        u_if.if_req    = 1'b0;
        u_if.if_addr   = 64'd0;
        u_if.if_flush  = 1'b0;
        u_if.mem_req   = 1'b0;
        u_if.mem_we    = 1'b0;
        u_if.mem_size  = 2'd0;
        u_if.mem_addr  = 64'd0;
        u_if.mem_wdata = 64'd0;
        u_if.bus_rdata = 64'd0;
        u_if.bus_ack   = 1'b0;
        u_if.bus_err   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({u_if.bus_req, u_if.bus_we, u_if.bus_size, u_if.if_ready, u_if.if_err,
             u_if.mem_ready, u_if.mem_err} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000", {u_if.bus_req, u_if.bus_we, u_if.bus_size,
                     u_if.if_ready, u_if.if_err, u_if.mem_ready, u_if.mem_err});
        end
        checks++;
        if ({u_if.bus_addr, u_if.bus_wdata, u_if.mem_rdata, u_if.if_rdata} !== 224'd0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want all zero", u_if.bus_addr, u_if.bus_wdata,
                     u_if.mem_rdata, u_if.if_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        u_if.if_req  = 1'b1;
        u_if.if_addr = 64'h1004;
        step();
        checks++;
        if ({u_if.bus_req, u_if.bus_we, u_if.bus_size} !== 4'b1010 || u_if.bus_addr !== 64'h1004) begin
            errors++;
            $display("FAIL fetch_grant: got req/we/size %b addr %h want 1010 addr 1004",
                     {u_if.bus_req, u_if.bus_we, u_if.bus_size}, u_if.bus_addr);
        end
        step();
        step();
        step();
        checks++;
        if (u_if.bus_req !== 1'b1 || u_if.if_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_wait: got req %b ready %b want 1 0", u_if.bus_req, u_if.if_ready);
        end
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 64'hDEADBEEF_00000013;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.if_ready !== 1'b1 || u_if.if_err !== 1'b0 || u_if.if_rdata !== 32'hDEADBEEF ||
            u_if.bus_req !== 1'b0 || u_if.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL fetch_done: got ready %b err %b rdata %h req %b want 1 0 deadbeef 0",
                     u_if.if_ready, u_if.if_err, u_if.if_rdata, u_if.bus_req);
        end
        u_if.if_req = 1'b0;
        step();
        checks++;
        if (u_if.if_ready !== 1'b0 || u_if.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse: got ready %b req %b want 0 0", u_if.if_ready, u_if.bus_req);
        end
    endtask

    task automatic test_contention();
        u_if.if_req    = 1'b1;
        u_if.if_addr   = 64'h3000;
        u_if.mem_req   = 1'b1;
        u_if.mem_we    = 1'b1;
        u_if.mem_size  = 2'd0;
        u_if.mem_addr  = 64'h8000_0000;
        u_if.mem_wdata = 64'h55;
        step();
        checks++;
        if ({u_if.bus_req, u_if.bus_we, u_if.bus_size} !== 4'b1100 || u_if.bus_wdata !== 64'h55 ||
            u_if.bus_addr !== 64'h8000_0000) begin
            errors++;
            $display("FAIL cont_mem_grant: got %b wdata %h addr %h want 1100 55 80000000",
                     {u_if.bus_req, u_if.bus_we, u_if.bus_size}, u_if.bus_wdata, u_if.bus_addr);
        end
        u_if.bus_ack = 1'b1;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.mem_ready !== 1'b1 || u_if.mem_err !== 1'b0 || u_if.if_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_mem_done: got mready %b merr %b iready %b want 1 0 0",
                     u_if.mem_ready, u_if.mem_err, u_if.if_ready);
        end
        u_if.mem_req = 1'b0;
        step();
        checks++;
        if (u_if.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL cont_idle: got req %b want 0", u_if.bus_req);
        end
        step();
        checks++;
        if ({u_if.bus_req, u_if.bus_we, u_if.bus_size} !== 4'b1010 || u_if.bus_addr !== 64'h3000) begin
            errors++;
            $display("FAIL cont_if_grant: got %b addr %h want 1010 3000",
                     {u_if.bus_req, u_if.bus_we, u_if.bus_size}, u_if.bus_addr);
        end
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 64'h11111111_22222222;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.if_ready !== 1'b1 || u_if.if_rdata !== 32'h22222222) begin
            errors++;
            $display("FAIL cont_if_done: got ready %b rdata %h want 1 22222222", u_if.if_ready, u_if.if_rdata);
        end
        u_if.if_req = 1'b0;
        step();
    endtask

    // ack_last=1: ack arrives in the last permitted busy cycle and must beat the timeout.
    task automatic test_timeout(input logic ack_last);
        int held;
        held = 0;
        u_if.mem_req   = 1'b1;
        u_if.mem_we    = 1'b0;
        u_if.mem_size  = 2'd3;
        u_if.mem_addr  = 64'h100;
        u_if.bus_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        step();
        for (int i = 0; i < 63; i++) begin
            if (u_if.bus_req === 1'b1 && u_if.mem_ready === 1'b0) held++;
            step();
        end
        checks++;
        if (held !== 63 || u_if.bus_req !== 1'b1) begin
            errors++;
            $display("FAIL to_held: got %0d cycles, req %b want 63 1", held, u_if.bus_req);
        end
        if (ack_last) begin
            u_if.bus_ack   = 1'b1;
            u_if.bus_rdata = 64'h1234;
        end
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (ack_last) begin
            if (u_if.mem_ready !== 1'b1 || u_if.mem_err !== 1'b0 || u_if.mem_rdata !== 64'h1234) begin
                errors++;
                $display("FAIL to_ack_wins: got ready %b err %b rdata %h want 1 0 1234",
                         u_if.mem_ready, u_if.mem_err, u_if.mem_rdata);
            end
        end else begin
            if (u_if.bus_req !== 1'b0 || u_if.mem_ready !== 1'b1 || u_if.mem_err !== 1'b1 ||
                u_if.mem_rdata !== 64'd0) begin
                errors++;
                $display("FAIL to_abort: got req %b ready %b err %b rdata %h want 0 1 1 0",
                         u_if.bus_req, u_if.mem_ready, u_if.mem_err, u_if.mem_rdata);
            end
        end
        u_if.mem_req = 1'b0;
        step();
        u_if.mem_req  = 1'b1;
        u_if.mem_addr = 64'h200;
        step();
        checks++;
        if (u_if.bus_req !== 1'b1 || u_if.bus_addr !== 64'h200 || u_if.bus_size !== 2'd3) begin
            errors++;
            $display("FAIL to_next_grant: got req %b addr %h size %0d want 1 200 3",
                     u_if.bus_req, u_if.bus_addr, u_if.bus_size);
        end
        step();
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 64'hCAFEF00D_12345678;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.mem_ready !== 1'b1 || u_if.mem_err !== 1'b0 || u_if.mem_rdata !== 64'hCAFEF00D_12345678) begin
            errors++;
            $display("FAIL to_next_done: got ready %b err %b rdata %h want 1 0 cafef00d12345678",
                     u_if.mem_ready, u_if.mem_err, u_if.mem_rdata);
        end
        u_if.mem_req = 1'b0;
        step();
    endtask

    task automatic test_flush();
        u_if.if_req  = 1'b1;
        u_if.if_addr = 64'h1008;
        step();
        u_if.if_flush = 1'b1;
        step();
        u_if.if_flush = 1'b0;
        step();
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 64'h77777777_66666666;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.if_ready !== 1'b0 || u_if.if_err !== 1'b0 || u_if.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_silent: got ready %b err %b req %b want 0 0 0",
                     u_if.if_ready, u_if.if_err, u_if.bus_req);
        end
        u_if.if_addr = 64'h2000;
        step();
        u_if.if_flush = 1'b1;
        step();
        u_if.if_flush = 1'b0;
        checks++;
        if (u_if.bus_req !== 1'b1 || u_if.bus_addr !== 64'h2000) begin
            errors++;
            $display("FAIL flush_regrant: got req %b addr %h want 1 2000", u_if.bus_req, u_if.bus_addr);
        end
        u_if.bus_ack   = 1'b1;
        u_if.bus_rdata = 64'hAAAAAAAA_BBBBBBBB;
        step();
        u_if.bus_ack = 1'b0;
        checks++;
        if (u_if.if_ready !== 1'b1 || u_if.if_rdata !== 32'hBBBBBBBB) begin
            errors++;
            $display("FAIL flush_next_done: got ready %b rdata %h want 1 bbbbbbbb", u_if.if_ready, u_if.if_rdata);
        end
        u_if.if_addr  = 64'h2004;
        u_if.if_flush = 1'b0;
        step();
        step();
        u_if.if_flush  = 1'b1;
        u_if.bus_ack   = 1'b1;
        u_if.bus_err   = 1'b1;
        step();
        u_if.if_flush = 1'b0;
        u_if.bus_ack  = 1'b0;
        u_if.bus_err  = 1'b0;
        checks++;
        if (u_if.if_ready !== 1'b0 || u_if.if_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_same_edge: got ready %b err %b want 0 0", u_if.if_ready, u_if.if_err);
        end
        u_if.if_req = 1'b0;
        step();
    endtask

    task automatic test_bus_err_and_reset();
        u_if.mem_req  = 1'b1;
        u_if.mem_we   = 1'b0;
        u_if.mem_size = 2'd2;
        u_if.mem_addr = 64'h400;
        step();
        u_if.bus_ack = 1'b1;
        u_if.bus_err = 1'b1;
        step();
        u_if.bus_ack = 1'b0;
        u_if.bus_err = 1'b0;
        checks++;
        if (u_if.mem_ready !== 1'b1 || u_if.mem_err !== 1'b1) begin
            errors++;
            $display("FAIL bus_err: got ready %b err %b want 1 1", u_if.mem_ready, u_if.mem_err);
        end
        u_if.mem_req = 1'b0;
        step();
        u_if.mem_req = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (u_if.bus_req !== 1'b0 || u_if.mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got req %b ready %b want 0 0", u_if.bus_req, u_if.mem_ready);
        end
        u_if.mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        u_if.bus_ack = 1'b1;
        step();
        u_if.bus_ack = 1'b0;
        step();
        checks++;
        if (u_if.mem_ready !== 1'b0 || u_if.if_ready !== 1'b0 || u_if.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: got mready %b iready %b req %b want 0 0 0",
                     u_if.mem_ready, u_if.if_ready, u_if.bus_req);
        end
    endtask

    task automatic test_starvation();
        logic exp_if;
        u_if.if_req    = 1'b1;
        u_if.if_addr   = 64'h4000;
        u_if.mem_req   = 1'b1;
        u_if.mem_we    = 1'b1;
        u_if.mem_size  = 2'd3;
        u_if.mem_addr  = 64'h9000;
        u_if.mem_wdata = 64'h99;
        for (int n = 0; n < 10; n++) begin
            step();
`ifdef ARB_STARVE_GUARD_EN
            exp_if = ((n % 5) == 4);
`else
            exp_if = 1'b0;
`endif
            checks++;
            if (u_if.bus_req !== 1'b1 ||
                u_if.bus_addr !== (exp_if ? 64'h4000 : 64'h9000) || u_if.bus_we !== !exp_if) begin
                errors++;
                $display("FAIL starve_grant%0d: got req %b addr %h we %b want IF=%b",
                         n, u_if.bus_req, u_if.bus_addr, u_if.bus_we, exp_if);
            end
            u_if.bus_ack = 1'b1;
            step();
            u_if.bus_ack = 1'b0;
            step();
        end
        u_if.if_req  = 1'b0;
        u_if.mem_req = 1'b0;
        step();
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_flush();
        test_bus_err_and_reset();
        test_starvation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle memory bus port between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Sits between fetch/memory and the unified memory/UART bus slave.
- Provides fixed data-over-fetch priority, a bus timeout that reports an access fault, and discard of fetches killed by a redirect.
- Its READY outputs drive the fetch-stage and memory-stage stall logic.

Parameters:
- TIMEOUT_CYCLES, 64: cycles BUS_REQ may stay high without BUS_ACK before the arbiter aborts with an error.
- TIMEOUT_W, 7: width of the timeout counter; must hold TIMEOUT_CYCLES.
- MAX_MEM_BURST, 4: consecutive MEM grants allowed while IF_REQ waits (only with the optional feature).

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IF_REQ  in  1  fetch request; level, held until IF_READY
- IF_ADDR  in  64  fetch address; 4-byte aligned
- IF_FLUSH  in  1  pulse: discard the outstanding fetch (redirect/trap)
- IF_RDATA  out  32  fetched instruction
- IF_READY  out  1  one-cycle completion pulse for fetch
- IF_ERR  out  1  fetch access fault; qualified by IF_READY
- MEM_REQ  in  1  data request; level, held until MEM_READY
- MEM_WE  in  1  1 = store
- MEM_SIZE  in  2  0=byte, 1=half, 2=word, 3=double
- MEM_ADDR  in  64  data address
- MEM_WDATA  in  64  store data
- MEM_RDATA  out  64  load data
- MEM_READY  out  1  one-cycle completion pulse for data
- MEM_ERR  out  1  data access fault; qualified by MEM_READY
- BUS_REQ  out  1  bus request; held until BUS_ACK or timeout
- BUS_WE  out  1  bus write enable
- BUS_SIZE  out  2  bus access size
- BUS_ADDR  out  64  bus address
- BUS_WDATA  out  64  bus write data
- BUS_RDATA  in  64  bus read data; valid with BUS_ACK
- BUS_ACK  in  1  one-cycle transfer-complete pulse
- BUS_ERR  in  1  bus error; qualified by BUS_ACK

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE, timeout counter 0, flush flag 0.
  - All outputs 0: BUS_REQ, BUS_WE, BUS_SIZE, BUS_ADDR, BUS_WDATA, IF_RDATA, IF_READY, IF_ERR, MEM_RDATA, MEM_READY, MEM_ERR.
  - Reset mid-transaction drops BUS_REQ immediately. A BUS_ACK arriving after reset is ignored.
- States: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- IDLE:
  - MEM_REQ=1 -> BUSY_MEM; MEM_REQ wins even if IF_REQ=1.
  - Else IF_REQ=1 -> BUSY_IF.
  - On the grant edge, BUS_ADDR/WE/SIZE/WDATA are registered from the winner and BUS_REQ is set to 1.
  - IF grants force BUS_WE=0 and BUS_SIZE=2.
- BUSY_x:
  - BUS_REQ stays 1 and bus outputs stay stable. The counter increments each cycle.
  - BUS_ACK=1 -> DONE_x. Capture the data and set ERR=BUS_ERR.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack -> DONE_x with ERR=1 and RDATA=0.
  - BUS_REQ falls on the same edge in both cases.
- DONE_x:
  - READY_x=1 for exactly this one cycle, then -> IDLE.
  - The requester must deassert or change its REQ on the edge after READY.
- Latency: with a slave ack k cycles after BUS_REQ rises, READY is high in cycle k+2 after the request is seen in IDLE. Minimum occupancy per transaction is k+3 cycles.
- Read data:
  - MEM_RDATA = BUS_RDATA unmodified; sign/zero extension belongs to the memory stage.
  - IF_RDATA = IF_ADDR[2] ? BUS_RDATA[63:32] : BUS_RDATA[31:0], using the latched address.
  - Alignment checks stay in fetch/memory; the arbiter does not check alignment.
- Flush:
  - IF_FLUSH in BUSY_IF sets the flush flag. The bus transaction still completes.
  - DONE_IF with the flag set suppresses IF_READY and IF_ERR, then clears the flag.
  - IF_FLUSH in IDLE, DONE_IF or any MEM state has no effect.
- Simultaneous events:
  - BUS_ACK on the timeout edge: the ack wins and ERR=BUS_ERR.
  - BUS_ACK in IDLE or DONE_x is ignored.
  - IF_FLUSH and BUS_ACK on the same edge: the fetch completes silently.
- Bus outputs hold their last value in IDLE and DONE; only BUS_REQ qualifies them.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A counter tracks consecutive MEM grants made while IF_REQ=1. It resets on any IF grant or whenever IF_REQ=0 in IDLE.
  - When the counter equals MAX_MEM_BURST, IF wins the next IDLE arbitration even if MEM_REQ=1.
- Undefined: strict MEM priority; the counter logic is absent.

Test Plan:
- Single fetch: IF_REQ=1, IF_ADDR=0x1004, slave acks 3 cycles after BUS_REQ with BUS_RDATA=0xDEADBEEF_00000013 -> BUS_ADDR=0x1004, BUS_WE=0, BUS_SIZE=2; IF_READY one cycle, IF_RDATA=0xDEADBEEF, IF_ERR=0.
- Contention: IF_REQ and MEM_REQ rise together, MEM store of 0x55 at 0x8000_0000 with size 0 -> MEM granted first (BUS_WE=1, BUS_WDATA=0x55, BUS_SIZE=0); after MEM_READY, the IF request is granted.
- Timeout: MEM load with no slave ack, TIMEOUT_CYCLES=64 -> BUS_REQ falls after 64 cycles; MEM_READY=1, MEM_ERR=1, MEM_RDATA=0; next request is accepted normally.
- Flush: IF_FLUSH pulsed mid BUSY_IF, ack arrives later -> no IF_READY; new IF_REQ at 0x2000 is granted from IDLE and returns normally.
- Bus error and reset: BUS_ACK with BUS_ERR=1 -> ERR=1 with READY. RESET low during BUSY_MEM -> BUS_REQ=0 immediately, no READY; a stray BUS_ACK after reset is ignored.
- With ARB_STARVE_GUARD_EN, MAX_MEM_BURST=4: MEM_REQ and IF_REQ held continuously -> grant pattern MEM,MEM,MEM,MEM,IF repeating. Without the macro -> MEM only, IF starves.
